return_address_stack: RTL

Speculative return address stack (RAS) at the other end of the branch predictor's RAS interface. Fetch pushes call return addresses and pops on predicted returns; a checkpoint FIFO records the stack pointer for every predicted control-flow instruction. The predictor's `branch_retired` drains checkpoints in order, and a flush restores the pointer to the oldest outstanding checkpoint. Sits in the fetch stage beside the branch predictor.

---
 rtl/return_address_stack_pkg.sv | 25 ++
 rtl/return_address_stack_ckpt_fifo.sv | 89 ++++++++
 rtl/return_address_stack.sv | 82 ++++++++
 3 files changed

// File: rtl/return_address_stack_pkg.sv
// +----------------------------------------------------------------------------+
// | return_address_stack_pkg: shared RAS types, default depths and helpers.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package return_address_stack_pkg;

  typedef struct packed {
    int entries;
    int ckpt_depth;
  } ras_config_t;

  localparam ras_config_t RAS_DEFAULT_CONFIG = '{entries: 8, ckpt_depth: 8};

  // Pointer width for a power-of-two depth; a one-entry structure still needs one bit.
  function automatic int ras_idx_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  typedef logic [ras_idx_width(RAS_DEFAULT_CONFIG.entries)-1:0] ras_checkpoint_t;

endpackage

`default_nettype wire

// File: rtl/return_address_stack_ckpt_fifo.sv
// +----------------------------------------------------------------------------+
// | ras_checkpoint_fifo: synchronous FIFO of saved stack pointers.             |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module ras_checkpoint_fifo
  import return_address_stack_pkg::*;
#(
  parameter int DEPTH = RAS_DEFAULT_CONFIG.ckpt_depth,
  parameter int WIDTH = ras_idx_width(RAS_DEFAULT_CONFIG.entries)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd,
  input  logic             clear,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = ras_idx_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr, do_rd;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  // A retire in the same cycle frees the slot a write into a full FIFO needs.
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  ap_no_dropped_write: assert property (@(posedge clk) disable iff (!rst_n)
      !(wr && !clear && full && !rd))
    else $warning("ras_checkpoint_fifo: checkpoint write dropped while full");

endmodule

`default_nettype wire

// File: rtl/return_address_stack.sv
// +----------------------------------------------------------------------------+
// | return_address_stack: speculative RAS with checkpointed pointer restore.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module return_address_stack
  import return_address_stack_pkg::*;
#(
  parameter int ENTRIES    = RAS_DEFAULT_CONFIG.entries,
  parameter int CKPT_DEPTH = RAS_DEFAULT_CONFIG.ckpt_depth
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] new_addr,
  output logic [31:0] addr,
  input  logic        branch_fetched,
  input  logic        branch_retired,
  input  logic        flush,
  output logic        ckpt_full
);

  localparam int IDX_W = ras_idx_width(ENTRIES);

  logic [31:0]      stack_q [ENTRIES];
  logic [31:0]      stack_d [ENTRIES];
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0] ckpt_oldest;
  logic             ckpt_empty;

  assign addr = stack_q[rd_idx_q];

  // Checkpoints capture the pointer before this cycle's push/pop takes effect.
  ras_checkpoint_fifo #(
    .DEPTH (CKPT_DEPTH),
    .WIDTH (IDX_W)
  ) u_ckpt_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .wr      (branch_fetched && !flush),
    .wr_data (rd_idx_q),
    .rd      (branch_retired && !flush),
    .clear   (flush),
    .rd_data (ckpt_oldest),
    .full    (ckpt_full),
    .empty   (ckpt_empty)
  );

  always_comb begin
    stack_d  = stack_q;
    rd_idx_d = rd_idx_q;
    if (flush) begin
      if (!ckpt_empty) begin
        rd_idx_d = ckpt_oldest;
      end
    end else if (push && pop) begin
      stack_d[rd_idx_q] = new_addr;
    end else if (push) begin
      rd_idx_d          = rd_idx_q + 1'b1;
      stack_d[rd_idx_d] = new_addr;
    end else if (pop) begin
      rd_idx_d = rd_idx_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        stack_q[i] <= '0;
      end
      rd_idx_q <= '0;
    end else begin
      stack_q  <= stack_d;
      rd_idx_q <= rd_idx_d;
    end
  end

endmodule

`default_nettype wire
